// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: emits a run of binary values from start_val to end_val
// (counting up or down, wrapping modulo 2^WIDTH) with a valid/ready
// handshake. Every element is presented in both binary and Gray form.
// One-cycle done pulse after the last element is accepted.

// bin_to_gray: combinational binary-to-Gray conversion.
module bin_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Each Gray bit is the XOR of the matching binary bit and its upper neighbour.
  assign gray = bin ^ (bin >> 1);

endmodule

module gray_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic             dir,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] end_reg;
  logic             dir_reg;
  logic             transfer;

  // An element is consumed whenever the consumer is ready while it is valid.
  assign transfer = out_valid & out_ready;

  // Binary output comes straight from the count register.
  assign out_bin = count;

  bin_to_gray #(.WIDTH(WIDTH)) u_bin_to_gray (
    .bin  (count),
    .gray (out_gray)
  );

  // Sequence FSM: captures the request, steps the count on each transfer and
  // drives the registered status outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; blocking would make results order-dependent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      end_reg   <= '0;
      dir_reg   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // start together with abort is treated as no request at all.
          if (start && !abort) begin
            count     <= start_val;
            end_reg   <= end_val;
            dir_reg   <= dir;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            // A coincident transfer is still accepted, but abort wins: no done.
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (transfer) begin
            if (count == end_reg) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else if (dir_reg) begin
              count <= count - 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        DONE: begin
          // Single-cycle completion; start and abort are ignored here.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Testbench for gray_seq_ctrl: table of directed vectors with hand-computed
// expectations, plus hand-written full-range and wrap-around sequences.
module tb_gray_seq_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] end_val;
  logic             dir;
  logic             abort;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_bin;
  logic [WIDTH-1:0] out_gray;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  gray_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_val (start_val),
    .end_val   (end_val),
    .dir       (dir),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_gray  (out_gray),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] sv;
    logic [3:0] ev;
    logic       dir;
    logic       abort;
    logic       rdy;
    logic       e_valid;
    logic [3:0] e_bin;
    logic [3:0] e_gray;
    logic       e_busy;
    logic       e_done;
    logic       chk_data;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic r, input logic s,
                     input logic [3:0] sv, input logic [3:0] ev, input logic d,
                     input logic a, input logic rdy, input logic e_valid,
                     input logic [3:0] e_bin, input logic [3:0] e_gray,
                     input logic e_busy, input logic e_done, input logic chk_data);
    vec_t v;
    v.name = name; v.rst = r; v.start = s; v.sv = sv; v.ev = ev; v.dir = d;
    v.abort = a; v.rdy = rdy; v.e_valid = e_valid; v.e_bin = e_bin;
    v.e_gray = e_gray; v.e_busy = e_busy; v.e_done = e_done; v.chk_data = chk_data;
    vecs.push_back(v);
  endtask

  // Apply inputs, cross one rising edge, then sample 1 ns later.
  task automatic drive_and_tick(input logic r, input logic s, input logic [3:0] sv,
                                input logic [3:0] ev, input logic d, input logic a,
                                input logic rdy);
    rst = r; start = s; start_val = sv; end_val = ev; dir = d; abort = a; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string name, input logic e_valid,
                              input logic e_busy, input logic e_done);
    check({name, ".valid"}, 32'(out_valid), 32'(e_valid));
    check({name, ".busy"},  32'(busy),      32'(e_busy));
    check({name, ".done"},  32'(done),      32'(e_done));
  endtask

  task automatic check_data(input string name, input logic [3:0] e_bin, input logic [3:0] e_gray);
    check({name, ".bin"},  32'(out_bin),  32'(e_bin));
    check({name, ".gray"}, 32'(out_gray), 32'(e_gray));
  endtask

  // Hand-written Gray codes for 0..15.
  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  initial begin
    //   name        rst st sv  ev  dir ab rdy   val bin  gray     busy done data
    add("reset",      1, 0, 0,  0,  0,  0, 0,    0,  0, 4'b0000,    0, 0, 1);
    // Down count 2 -> 14 wrapping through 0/15
    add("dn_start",   0, 1, 2,  14, 1,  0, 1,    1,  2, 4'b0011,    1, 0, 1);
    add("dn_1",       0, 0, 2,  14, 1,  0, 1,    1,  1, 4'b0001,    1, 0, 1);
    add("dn_0",       0, 0, 2,  14, 1,  0, 1,    1,  0, 4'b0000,    1, 0, 1);
    add("dn_15",      0, 0, 2,  14, 1,  0, 1,    1, 15, 4'b1000,    1, 0, 1);
    add("dn_14",      0, 0, 2,  14, 1,  0, 1,    1, 14, 4'b1001,    1, 0, 1);
    add("dn_done",    0, 0, 2,  14, 1,  0, 1,    0,  0, 4'b0000,    0, 1, 0);
    add("dn_idle",    0, 0, 2,  14, 1,  0, 1,    0,  0, 4'b0000,    0, 0, 0);
    // Up 5 -> 7 with backpressure on 6; config/start changes while busy ignored
    add("bp_start",   0, 1, 5,  7,  0,  0, 0,    1,  5, 4'b0111,    1, 0, 1);
    add("bp_6",       0, 0, 5,  7,  0,  0, 1,    1,  6, 4'b0101,    1, 0, 1);
    add("bp_hold1",   0, 1, 1,  1,  1,  0, 0,    1,  6, 4'b0101,    1, 0, 1);
    add("bp_hold2",   0, 1, 1,  1,  1,  0, 0,    1,  6, 4'b0101,    1, 0, 1);
    add("bp_hold3",   0, 0, 1,  1,  1,  0, 0,    1,  6, 4'b0101,    1, 0, 1);
    add("bp_7",       0, 0, 1,  1,  1,  0, 1,    1,  7, 4'b0100,    1, 0, 1);
    add("bp_done",    0, 0, 1,  1,  1,  0, 1,    0,  0, 4'b0000,    0, 1, 0);
    add("bp_idle",    0, 0, 1,  1,  1,  0, 1,    0,  0, 4'b0000,    0, 0, 0);
    // Abort on element 10 while it is being accepted
    add("ab_start",   0, 1, 9,  12, 0,  0, 0,    1,  9, 4'b1101,    1, 0, 1);
    add("ab_10",      0, 0, 9,  12, 0,  0, 1,    1, 10, 4'b1111,    1, 0, 1);
    add("ab_abort",   0, 0, 9,  12, 0,  1, 1,    0,  0, 4'b0000,    0, 0, 0);
    add("ab_nodone",  0, 0, 9,  12, 0,  0, 1,    0,  0, 4'b0000,    0, 0, 0);
    // Reset mid-sequence overriding start/abort/handshake
    add("rs_start",   0, 1, 3,  10, 0,  0, 0,    1,  3, 4'b0010,    1, 0, 1);
    add("rs_reset",   1, 1, 3,  10, 0,  1, 1,    0,  0, 4'b0000,    0, 0, 1);
    add("rs_restart", 0, 1, 4,  5,  0,  0, 0,    1,  4, 4'b0110,    1, 0, 1);
    add("rs_5",       0, 0, 4,  5,  0,  0, 1,    1,  5, 4'b0111,    1, 0, 1);
    add("rs_done",    0, 0, 4,  5,  0,  0, 1,    0,  0, 4'b0000,    0, 1, 0);
    add("rs_idle",    0, 0, 4,  5,  0,  0, 1,    0,  0, 4'b0000,    0, 0, 0);
    // Single element 6 with start held high through RUN and DONE
    add("one_start",  0, 1, 6,  6,  0,  0, 0,    1,  6, 4'b0101,    1, 0, 1);
    add("one_done",   0, 1, 6,  6,  0,  0, 1,    0,  0, 4'b0000,    0, 1, 0);
    add("one_nore",   0, 1, 6,  6,  0,  0, 1,    0,  0, 4'b0000,    0, 0, 0);
    add("one_idle",   0, 0, 6,  6,  0,  0, 1,    0,  0, 4'b0000,    0, 0, 0);
    // start with abort in IDLE ignored; abort in RUN without ready
    add("ig_start",   0, 1, 1,  1,  0,  1, 0,    0,  0, 4'b0000,    0, 0, 0);
    add("ig_go",      0, 1, 1,  1,  0,  0, 0,    1,  1, 4'b0001,    1, 0, 1);
    add("ig_abort",   0, 0, 1,  1,  0,  1, 0,    0,  0, 4'b0000,    0, 0, 0);
    add("ig_quiet",   0, 0, 1,  1,  0,  0, 0,    0,  0, 4'b0000,    0, 0, 0);

    rst = 1'b1; start = 1'b0; start_val = '0; end_val = '0;
    dir = 1'b0; abort = 1'b0; out_ready = 1'b0;

    foreach (vecs[i]) begin
      drive_and_tick(vecs[i].rst, vecs[i].start, vecs[i].sv, vecs[i].ev,
                     vecs[i].dir, vecs[i].abort, vecs[i].rdy);
      check_status(vecs[i].name, vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_done);
      if (vecs[i].chk_data)
        check_data(vecs[i].name, vecs[i].e_bin, vecs[i].e_gray);
    end

    // Full range 0..15 upward, ready held high: one element per cycle.
    begin
      int transfers = 0;
      drive_and_tick(0, 1, 0, 15, 0, 0, 1);
      for (int i = 0; i < 16; i++) begin
        check_status($sformatf("full_%0d", i), 1, 1, 0);
        check_data($sformatf("full_%0d", i), 4'(i), gray_tab[i]);
        if (out_valid && out_ready) transfers++;
        drive_and_tick(0, 0, 0, 15, 0, 0, 1);
      end
      check("full_transfers", 32'(transfers), 32'd16);
      check_status("full_done", 0, 0, 1);
      drive_and_tick(0, 0, 0, 15, 0, 0, 1);
      check_status("full_idle", 0, 0, 0);
    end

    // Upward wrap 14,15,0,1.
    begin
      logic [3:0] wb [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
      logic [3:0] wg [4] = '{4'b1001, 4'b1000, 4'b0000, 4'b0001};
      int waited = 0;
      drive_and_tick(0, 1, 14, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
        check_status($sformatf("wrap_%0d", i), 1, 1, 0);
        check_data($sformatf("wrap_%0d", i), wb[i], wg[i]);
        drive_and_tick(0, 0, 14, 1, 0, 0, 1);
      end
      // Bounded wait for the done pulse.
      while (!done && waited < 4) begin
        drive_and_tick(0, 0, 14, 1, 0, 0, 1);
        waited++;
      end
      check("wrap_done_latency", 32'(waited), 32'd0);
      check_status("wrap_done", 0, 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
